// File: rtl/assoc_dmem_pkg.sv
// Shared definitions for the associative data memory: request decode and
// byte-lane merge helper.
package assoc_dmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RDWR,
        INV
    } req_kind_t;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned MERGE_W     = 512;
    localparam int unsigned MERGE_BYTES = MERGE_W / 8;

    function automatic req_kind_t decode_req(
        input logic cs,
        input logic we,
        input logic oe,
        input logic inv
    );
        req_kind_t kind;
        kind = IDLE;
        if (cs) begin
            if (inv)
                kind = INV;
            else if (we && oe)
                kind = RDWR;
            else if (we)
                kind = WR;
            else if (oe)
                kind = RD;
        end
        return kind;
    endfunction

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]     old_word,
        input logic [MERGE_W-1:0]     new_word,
        input logic [MERGE_BYTES-1:0] be
    );
        logic [MERGE_W-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MERGE_BYTES; i++) begin
            if (be[i])
                merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/assoc_dmem_ffs.sv
// Find-first-set: lowest asserted index of req plus an any-set flag.
module assoc_dmem_ffs #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any_set
);

    localparam int unsigned IDX_W = $clog2(N);

    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !any_set) begin
                idx     = IDX_W'(i);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/assoc_dmem.sv
// Sparse associative data memory: allocate-on-write, byte-writable, registered
// read port with invalidate, occupancy count and miss/full reporting.
module assoc_dmem
    import assoc_dmem_pkg::*;
#(
    parameter int unsigned       DEPTH    = 64,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] MISS_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cs,
    input  logic                       we,
    input  logic                       oe,
    input  logic                       inv,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W/8-1:0]        be,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       rvalid,
    output logic                       hit,
    output logic                       wr_done,
    output logic                       wr_err,
    output logic                       inv_done,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] tags [DEPTH];
    logic [DATA_W-1:0] mem  [DEPTH];

    logic [DEPTH-1:0]  hit_vec;
    logic [DEPTH-1:0]  free_vec;
    logic              lookup_hit;
    logic [DATA_W-1:0] hit_data;
    logic [DATA_W-1:0] wr_word;
    logic [IDX_W-1:0]  alloc_idx;
    logic              any_free;

    req_kind_t kind;
    logic      is_rd;
    logic      is_wr;
    logic      is_inv;
    logic      do_wr_hit;
    logic      do_alloc;
    logic      wr_fail;
    logic      inv_hit;

    // hit_vec is one-hot or zero, so OR-reducing gated words selects the hit entry.
    always_comb begin
        hit_vec  = '0;
        hit_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit_vec[i] = valid[i] && (tags[i] == addr);
            if (hit_vec[i])
                hit_data = hit_data | mem[i];
        end
    end

    assign lookup_hit = |hit_vec;
    assign free_vec   = ~valid;

    assoc_dmem_ffs #(
        .N(DEPTH)
    ) u_ffs (
        .req     (free_vec),
        .idx     (alloc_idx),
        .any_set (any_free)
    );

    // On a miss hit_data is zero, so one merge covers both update and allocate.
    always_comb begin
        kind      = decode_req(cs, we, oe, inv);
        is_rd     = (kind == RD) || (kind == RDWR);
        is_wr     = (kind == WR) || (kind == RDWR);
        is_inv    = (kind == INV);
        do_wr_hit = is_wr && lookup_hit;
        do_alloc  = is_wr && !lookup_hit && any_free;
        wr_fail   = is_wr && !lookup_hit && !any_free;
        inv_hit   = is_inv && lookup_hit;
        wr_word   = DATA_W'(byte_merge(MERGE_W'(hit_data), MERGE_W'(din), MERGE_BYTES'(be)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            dout     <= '0;
            rvalid   <= 1'b0;
            hit      <= 1'b0;
            wr_done  <= 1'b0;
            wr_err   <= 1'b0;
            inv_done <= 1'b0;
            count    <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (inv_hit && hit_vec[i])
                    valid[i] <= 1'b0;
                if (do_alloc && (alloc_idx == IDX_W'(i)))
                    valid[i] <= 1'b1;
            end
            if (do_alloc && (count != CNT_W'(DEPTH)))
                count <= count + 1'b1;
            else if (inv_hit && (count != '0))
                count <= count - 1'b1;
            rvalid   <= is_rd;
            hit      <= lookup_hit && (is_rd || is_wr || is_inv);
            wr_done  <= do_wr_hit || do_alloc;
            wr_err   <= wr_fail;
            inv_done <= is_inv;
            if (is_rd)
                dout <= lookup_hit ? hit_data : MISS_VAL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((do_wr_hit && hit_vec[i]) || (do_alloc && (alloc_idx == IDX_W'(i)))) begin
                    tags[i] <= addr;
                    mem[i]  <= wr_word;
                end
            end
        end
    end

    assign full = (count == CNT_W'(DEPTH));

endmodule
